pwm_naar_level: RTL and testbench

//  Decoder for the level->PWM path: measures an incoming PWM signal (period PERIOD clk, duty 5/20/40/60/80 %)
//  and recovers the 3-bit level plus the raw high-time count. Sits on the receive side of the motor/servo link,

---
 rtl/pwm_naar_level_pkg.sv | 50 +++++
 rtl/pwm_naar_level_if.sv | 21 ++
 rtl/pwm_naar_level_edge_sync.sv | 69 ++++++
 rtl/pwm_naar_level.sv | 126 ++++++++++++
 tb/tb_pwm_naar_level.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_naar_level_pkg.sv
// Shared constants, types and helpers for the PWM -> level decoder.
// Duty thresholds are midpoints of adjacent duty steps at the nominal period.
package pwm_naar_level_pkg;

   localparam int unsigned PERIOD_DEF   = 24000;
   localparam int unsigned PER_TOL_DEF  = 1200;
   localparam int unsigned TIMEOUT_DEF  = 65535;
   localparam int unsigned FILT_LEN_DEF = 4;

   localparam int unsigned TH_5_20  = 3000;
   localparam int unsigned TH_20_40 = 7200;
   localparam int unsigned TH_40_60 = 12000;
   localparam int unsigned TH_60_80 = 16800;

   typedef logic [2:0] lvl_t;

   localparam lvl_t LVL_5  = 3'd0;
   localparam lvl_t LVL_20 = 3'd1;
   localparam lvl_t LVL_40 = 3'd2;
   localparam lvl_t LVL_60 = 3'd3;
   localparam lvl_t LVL_80 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEAS,
      ST_TOUT
   } state_e;

   // Thresholds track the configured period so a shorter link keeps the same duty split.
   function automatic logic [15:0] scale_th(int unsigned th, int unsigned period);
      return 16'(th * period / PERIOD_DEF);
   endfunction

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic lvl_t classify(logic [15:0] hi, logic [15:0] t0,
                                     logic [15:0] t1, logic [15:0] t2,
                                     logic [15:0] t3);
      lvl_t l;
      if (hi < t0)      l = LVL_5;
      else if (hi < t1) l = LVL_20;
      else if (hi < t2) l = LVL_40;
      else if (hi < t3) l = LVL_60;
      else              l = LVL_80;
      return l;
   endfunction

endpackage

// File: rtl/pwm_naar_level_if.sv
// Receive-side bundle: raw PWM in, decoded level/high time/status out.
interface pwm_naar_level_if;
   import pwm_naar_level_pkg::*;

   logic        pwm_in;
   lvl_t        level;
   logic [15:0] high_cnt;
   logic        valid;
   logic        per_err;
   logic        timeout;

   modport slave (
      input  pwm_in,
      output level, high_cnt, valid, per_err, timeout
   );

   modport master (
      output pwm_in,
      input  level, high_cnt, valid, per_err, timeout
   );
endinterface

// File: rtl/pwm_naar_level_edge_sync.sv
// 2-flop synchronizer, optional deglitch filter (PWM_FILTER_EN), rise detect.
// The filter delays both edges equally, so measured high time is unaffected.
module pwm_naar_level_edge_sync
   import pwm_naar_level_pkg::*;
`ifdef PWM_FILTER_EN
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEF
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic pwm_i,
   output logic lvl_o,
   output logic rise_o
);

   logic s1_q, s2_q, prev_q;
   logic lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= pwm_i;
         s2_q <= s1_q;
      end
   end

`ifdef PWM_FILTER_EN
   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) filt_d = s2_q;
         else                            cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = s2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= lvl;
   end

   assign lvl_o  = lvl;
   assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/pwm_naar_level.sv
// Measures PWM period/high time and recovers the 0..4 level code.
// Build option: define PWM_FILTER_EN to insert the deglitch filter.
module pwm_naar_level
   import pwm_naar_level_pkg::*;
#(
   parameter int unsigned PERIOD   = PERIOD_DEF,
   parameter int unsigned PER_TOL  = PER_TOL_DEF,
`ifdef PWM_FILTER_EN
   parameter int unsigned FILT_LEN = FILT_LEN_DEF,
`endif
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
   input logic           clk,
   input logic           rst,
   pwm_naar_level_if.slave bus
);

   localparam logic [15:0] TH0    = scale_th(TH_5_20, PERIOD);
   localparam logic [15:0] TH1    = scale_th(TH_20_40, PERIOD);
   localparam logic [15:0] TH2    = scale_th(TH_40_60, PERIOD);
   localparam logic [15:0] TH3    = scale_th(TH_60_80, PERIOD);
   localparam logic [15:0] PER_LO = 16'(PERIOD - PER_TOL);
   localparam logic [15:0] PER_HI = 16'(PERIOD + PER_TOL);
   localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] per_q, per_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] high_q, high_d;
   lvl_t        level_q, level_d;
   logic        valid_q, valid_d;
   logic        perr_q, perr_d;
   logic        tout_q, tout_d;
   logic        sync, rise;

   pwm_naar_level_edge_sync
`ifdef PWM_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
      u_sync (
         .clk    (clk),
         .rst    (rst),
         .pwm_i  (bus.pwm_in),
         .lvl_o  (sync),
         .rise_o (rise)
      );

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      hi_d    = hi_q;
      high_d  = high_q;
      level_d = level_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      tout_d  = tout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_MEAS;
               per_d   = 16'd1;
               hi_d    = 16'd1;
            end
         end
         ST_MEAS: begin
            // The rise cycle opens the next period, so it counts as 1.
            if (rise) begin
               high_d  = hi_q;
               level_d = classify(hi_q, TH0, TH1, TH2, TH3);
               perr_d  = (per_q < PER_LO) | (per_q > PER_HI);
               valid_d = 1'b1;
               per_d   = 16'd1;
               hi_d    = 16'd1;
            end else begin
               per_d = sat_inc(per_q);
               if (sync) hi_d = sat_inc(hi_q);
               if (per_q >= TO_M1) begin
                  state_d = ST_TOUT;
                  tout_d  = 1'b1;
                  level_d = sync ? LVL_80 : LVL_5;
               end
            end
         end
         ST_TOUT: begin
            if (rise) begin
               state_d = ST_MEAS;
               tout_d  = 1'b0;
               per_d   = 16'd1;
               hi_d    = 16'd1;
            end else begin
               level_d = sync ? LVL_80 : LVL_5;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         hi_q    <= '0;
         high_q  <= '0;
         level_q <= LVL_5;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         hi_q    <= hi_d;
         high_q  <= high_d;
         level_q <= level_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         tout_q  <= tout_d;
      end
   end

   assign bus.level    = level_q;
   assign bus.high_cnt = high_q;
   assign bus.valid    = valid_q;
   assign bus.per_err  = perr_q;
   assign bus.timeout  = tout_q;

endmodule

// File: tb/tb_pwm_naar_level.sv
// Bench for pwm_naar_level at a shortened period, with a duty-cycle reference model.
// Expectations for the glitch scenario follow PWM_FILTER_EN if it is defined.
module tb_pwm_naar_level;

   localparam int P   = 1200;
   localparam int TOL = 60;
   localparam int TO  = 3000;

   typedef struct packed {
      logic [2:0]  lvl;
      logic [15:0] hi;
      logic        perr;
   } pub_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_naar_level_if bus();

   pwm_naar_level #(
      .PERIOD  (P),
      .PER_TOL (TOL),
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   vecs = 0;
   int   errs = 0;
   pub_t exp_q[$];
   pub_t obs_q[$];
   int   armed = 0;
   int   prev_hi = 0;
   int   prev_per = 0;
   int   dbl_valid = 0;
   logic valid_d1 = 1'b0;

   always @(negedge clk) begin
      if (!rst && bus.valid) begin
         obs_q.push_back('{bus.level, bus.high_cnt, bus.per_err});
         if (valid_d1) dbl_valid++;
      end
      valid_d1 = !rst && bus.valid;
   end

   // Level from duty fraction: split points 12.5/30/50/70 % of the nominal period.
   function automatic pub_t model(int hi, int per);
      pub_t r;
      if (hi * 8 < P)            r.lvl = 3'd0;
      else if (hi * 10 < 3 * P)  r.lvl = 3'd1;
      else if (hi * 2 < P)       r.lvl = 3'd2;
      else if (hi * 10 < 7 * P)  r.lvl = 3'd3;
      else                       r.lvl = 3'd4;
      r.hi   = 16'(hi);
      r.perr = (per < P - TOL) || (per > P + TOL);
      return r;
   endfunction

   // A rising edge completes the previous period, if one was being timed.
   task automatic begin_period(int hi, int per);
      if (armed != 0 && prev_per < TO) exp_q.push_back(model(prev_hi, prev_per));
      armed    = 1;
      prev_hi  = hi;
      prev_per = per;
      bus.pwm_in = 1'b1;
   endtask

   task automatic drive_period(int hi, int per);
      begin_period(hi, per);
      repeat (hi) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (per - hi) @(negedge clk);
   endtask

   task automatic test_reset();
      pub_t e, o;
      bus.pwm_in = 1'b0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      vecs++;
      if ({bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout} !== 22'd0) begin
         errs++;
         $display("FAIL reset_hold got %0h want 0",
                  {bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      vecs++;
      if ({bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout} !== 22'd0) begin
         errs++;
         $display("FAIL reset_release got %0h want 0",
                  {bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout});
      end
      armed = 0;
   endtask

   task automatic test_duty20();
      pub_t e, o;
      repeat (3) drive_period(240, P);
      vecs++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         errs++;
         $display("FAIL duty20_count got %0d want 2", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL duty20 got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_sweep();
      pub_t e, o;
      int d[4];
      d = '{5, 40, 60, 80};
      for (int i = 0; i < 4; i++)
         drive_period(P * d[i] / 100 + int'($urandom_range(0, 6)) - 3,
                      P + int'($urandom_range(0, 40)) - 20);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL sweep_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL sweep got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_per_err();
      pub_t e, o;
      drive_period(400, 1000);
      begin_period(480, P);
      repeat (480) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (120) @(negedge clk);
      vecs++;
      if (bus.per_err !== 1'b1 || bus.level !== 3'd2) begin
         errs++;
         $display("FAIL per_err_sticky got perr=%0b lvl=%0d want perr=1 lvl=2",
                  bus.per_err, bus.level);
      end
      repeat (600) @(negedge clk);
      drive_period(480, P);
      vecs++;
      if (bus.per_err !== 1'b0) begin
         errs++;
         $display("FAIL per_err_clear got %0b want 0", bus.per_err);
      end
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL per_err_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL per_err got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout();
      pub_t e, o;
      begin_period(3500, 4100);
      repeat (3500) @(negedge clk);
      vecs++;
      if (bus.timeout !== 1'b1 || bus.level !== 3'd4) begin
         errs++;
         $display("FAIL tout_high got to=%0b lvl=%0d want to=1 lvl=4", bus.timeout, bus.level);
      end
      bus.pwm_in = 1'b0;
      repeat (600) @(negedge clk);
      vecs++;
      if (bus.timeout !== 1'b1 || bus.level !== 3'd0) begin
         errs++;
         $display("FAIL tout_low got to=%0b lvl=%0d want to=1 lvl=0", bus.timeout, bus.level);
      end
      begin_period(720, P);
      repeat (12) @(negedge clk);
      vecs++;
      if (bus.timeout !== 1'b0) begin
         errs++;
         $display("FAIL tout_clear got %0b want 0", bus.timeout);
      end
      repeat (708) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (480) @(negedge clk);
      drive_period(720, P);
      drive_period(720, P);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL tout_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL tout got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      pub_t e, o;
      begin_period(240, P);
      repeat (600) @(negedge clk);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL rmid_pre_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL rmid_pre got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      rst = 1'b1;
      #1;
      vecs++;
      if ({bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout} !== 22'd0) begin
         errs++;
         $display("FAIL rmid_async got %0h want 0",
                  {bus.level, bus.high_cnt, bus.valid, bus.per_err, bus.timeout});
      end
      bus.pwm_in = 1'b0;
      armed = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) drive_period(P * 60 / 100, P);
      vecs++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         errs++;
         $display("FAIL rmid_count got %0d want 2", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL rmid got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_glitch();
      pub_t e, o;
`ifdef PWM_FILTER_EN
      begin_period(240, P);
`else
      begin_period(100, 102);
`endif
      repeat (100) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (2) @(negedge clk);
`ifdef PWM_FILTER_EN
      bus.pwm_in = 1'b1;
`else
      begin_period(138, P - 102);
`endif
      repeat (138) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (P - 240) @(negedge clk);
      drive_period(240, P);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL glitch got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      pub_t e, o;
      int d[5];
      d = '{5, 20, 40, 60, 80};
      for (int i = 0; i < 8; i++)
         drive_period(P * d[$urandom_range(0, 4)] / 100 + int'($urandom_range(0, 40)) - 20,
                      P + int'($urandom_range(0, 200)) - 100);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL random got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_boundary();
      pub_t e, o;
      int pr[5];
      pr = '{P - TOL, P + TOL, P - TOL - 1, P + TOL + 1, P};
      for (int i = 0; i < 5; i++) drive_period(480, pr[i]);
      vecs++;
      if (obs_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL bound_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vecs++;
         if (o !== e) begin errs++; $display("FAIL bound got %p want %p", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_valid_width();
      vecs++;
      if (dbl_valid != 0) begin
         errs++;
         $display("FAIL valid_width got %0d long pulses want 0", dbl_valid);
      end
   endtask

   initial begin
      bus.pwm_in = 1'b0;
      test_reset();
      test_duty20();
      test_sweep();
      test_per_err();
      test_timeout();
      test_reset_mid();
      test_glitch();
      test_random();
      test_boundary();
      test_valid_width();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
